jtdsp16_dataram: RTL

Data RAM responder for the DSP16 core. It is the target of the 11-bit address produced by the YAAU, and it returns the ram_dout word that the YAAU and the data path consume. DSP writes pass through a one-entry posted write buffer with read bypass. A secondary host port, used for debug and for initialising coefficients, steals idle cycles and has a starvation guard that stalls the DSP.

---
 rtl/jtdsp16_dataram.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/jtdsp16_dataram.sv
// Data RAM responder for the DSP16 core. DSP writes are posted through a
// one-entry buffer with read bypass; a secondary host port steals idle
// cycles and forces a DSP stall when it has waited too long.
module jtdsp16_dataram #(
    parameter int unsigned AW     = 11,
    parameter int unsigned DW     = 16,
    parameter int unsigned STARVE = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic [AW-1:0] ram_addr,
    input  logic          ram_rd,
    input  logic          ram_we,
    input  logic [DW-1:0] ram_din,
    output logic [DW-1:0] ram_dout,
    output logic          dsp_stall,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_din,
    output logic          host_ack,
    output logic [DW-1:0] host_dout
);

    localparam int unsigned CW = $clog2(STARVE + 1);
    localparam logic [CW-1:0] StarveC = CW'(STARVE);

    // Storage array: not reset, single write port shared by commit and host
    logic [DW-1:0] mem_q [2**AW];

    logic          wb_valid_q, wb_valid_d;
    logic [AW-1:0] wb_addr_q, wb_addr_d;
    logic [DW-1:0] wb_data_q, wb_data_d;
    logic [DW-1:0] ram_dout_q, ram_dout_d;
    logic [DW-1:0] host_dout_q, host_dout_d;
    logic          host_ack_q, host_ack_d;
    logic          dsp_stall_q, dsp_stall_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          rd_acc, we_acc, grant, commit;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] dsp_word, host_word;

    // Request qualification, host arbitration and array write-port selection
    always_comb begin
        rd_acc    = cen & ram_rd & ~dsp_stall_q;
        we_acc    = cen & ram_we & ~dsp_stall_q;
        // A host grant never coincides with a commit because it needs wb_valid=0
        grant     = cen & host_req & ~host_ack_q & ~wb_valid_q &
                    (dsp_stall_q | (~ram_rd & ~ram_we));
        // Any cen edge with a valid entry drains it: either replaced or idle
        commit    = cen & wb_valid_q;
        dsp_word  = mem_q[ram_addr];
        host_word = mem_q[host_addr];
        mem_we    = 1'b0;
        mem_waddr = wb_addr_q;
        mem_wdata = wb_data_q;
        if (commit) begin
            mem_we = 1'b1;
        end else if (grant && host_we) begin
            mem_we    = 1'b1;
            mem_waddr = host_addr;
            mem_wdata = host_din;
        end
    end

    // Next-state for the write buffer, read data, host handshake and starvation guard
    always_comb begin
        wb_valid_d  = wb_valid_q;
        wb_addr_d   = wb_addr_q;
        wb_data_d   = wb_data_q;
        ram_dout_d  = ram_dout_q;
        host_dout_d = host_dout_q;
        host_ack_d  = host_ack_q;
        dsp_stall_d = dsp_stall_q;
        cnt_d       = cnt_q;

        if (cen) begin
            if (we_acc) begin
                wb_valid_d = 1'b1;
                wb_addr_d  = ram_addr;
                wb_data_d  = ram_din;
            end else begin
                wb_valid_d = 1'b0;
            end

            // Read sees the buffer as it was before this edge's write
            if (rd_acc) begin
                if (wb_valid_q && (ram_addr == wb_addr_q)) begin
                    ram_dout_d = wb_data_q;
                end else begin
                    ram_dout_d = dsp_word;
                end
            end

            host_ack_d = grant;
            if (grant && !host_we) begin
                host_dout_d = host_word;
            end

            if (!host_req || grant) begin
                cnt_d = '0;
            end else if (cnt_q < StarveC) begin
                cnt_d = cnt_q + CW'(1);
            end

            if (!host_req || grant) begin
                dsp_stall_d = 1'b0;
            end else if (cnt_d == StarveC) begin
                dsp_stall_d = 1'b1;
            end
        end
    end

    // Control and output registers; reset drops any pending buffered write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid_q  <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            ram_dout_q  <= '0;
            host_dout_q <= '0;
            host_ack_q  <= 1'b0;
            dsp_stall_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            wb_valid_q  <= wb_valid_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
            ram_dout_q  <= ram_dout_d;
            host_dout_q <= host_dout_d;
            host_ack_q  <= host_ack_d;
            dsp_stall_q <= dsp_stall_d;
            cnt_q       <= cnt_d;
        end
    end

    // Array write port
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign ram_dout  = ram_dout_q;
    assign host_dout = host_dout_q;
    assign host_ack  = host_ack_q;
    assign dsp_stall = dsp_stall_q;

endmodule
